// File: rtl/count_direction_decoder_if.sv
// Bundle of the count sample stream and the decoded direction outputs.
// Master drives samples; slave is the decoder.
interface count_direction_decoder_if #(
    parameter int BITS = 4
);
    logic [BITS-1:0] count;
    logic            count_valid;
    logic            clear;
    logic            dir;
    logic            dir_valid;
    logic            up_step;
    logic            down_step;
    logic            hold;
    logic            wrap;
    logic            err;
    logic [7:0]      rev_count;

    modport master (
        output count, count_valid, clear,
        input  dir, dir_valid, up_step, down_step, hold, wrap, err, rev_count
    );

    modport slave (
        input  count, count_valid, clear,
        output dir, dir_valid, up_step, down_step, hold, wrap, err, rev_count
    );
endinterface

// File: rtl/count_direction_decoder.sv
// Recovers the count direction of an up/down counter from successive samples,
// flagging steps, holds, wraps, illegal jumps and direction reversals.
//
// state  | meaning
// EMPTY  | no reference sample; next valid sample becomes prev
// PRIMED | reference known, direction not yet seen
// UP     | last accepted step was +1
// DOWN   | last accepted step was -1
// FAULT  | illegal jump seen; samples ignored until clear/reset
module count_direction_decoder #(
    parameter int BITS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    count_direction_decoder_if.slave bus
);
    typedef enum logic [2:0] {EMPTY, PRIMED, UP, DOWN, FAULT} state_t;

    localparam logic [BITS-1:0] MAX = '1;

    state_t          state;
    logic [BITS-1:0] prev;
    logic [BITS-1:0] delta;
    logic            is_up;
    logic            is_down;
    logic            is_hold;

    logic            dir_r;
    logic            dir_valid_r;
    logic            up_step_r;
    logic            down_step_r;
    logic            hold_r;
    logic            wrap_r;
    logic            err_r;
    logic [7:0]      rev_count_r;

    // With BITS = 1 a delta of 1 is also 2^BITS-1; the up step takes priority.
    assign delta   = bus.count - prev;
    assign is_up   = (delta == BITS'(1));
    assign is_down = !is_up && (delta == MAX);
    assign is_hold = (delta == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= PRIMED;
            prev        <= MAX;
            dir_r       <= 1'b0;
            dir_valid_r <= 1'b0;
            up_step_r   <= 1'b0;
            down_step_r <= 1'b0;
            hold_r      <= 1'b0;
            wrap_r      <= 1'b0;
            err_r       <= 1'b0;
            rev_count_r <= 8'd0;
        end else begin
            up_step_r   <= 1'b0;
            down_step_r <= 1'b0;
            hold_r      <= 1'b0;
            wrap_r      <= 1'b0;
            if (bus.clear) begin
                state       <= EMPTY;
                err_r       <= 1'b0;
                dir_valid_r <= 1'b0;
            end else if (bus.count_valid) begin
                case (state)
                    EMPTY: begin
                        prev  <= bus.count;
                        state <= PRIMED;
                    end
                    PRIMED, UP, DOWN: begin
                        if (is_hold) begin
                            hold_r <= 1'b1;
                        end else if (is_up) begin
                            if (state == DOWN && rev_count_r != 8'hFF)
                                rev_count_r <= rev_count_r + 8'd1;
                            state       <= UP;
                            dir_r       <= 1'b1;
                            dir_valid_r <= 1'b1;
                            up_step_r   <= 1'b1;
                            wrap_r      <= (prev == MAX);
                            prev        <= bus.count;
                        end else if (is_down) begin
                            if (state == UP && rev_count_r != 8'hFF)
                                rev_count_r <= rev_count_r + 8'd1;
                            state       <= DOWN;
                            dir_r       <= 1'b0;
                            dir_valid_r <= 1'b1;
                            down_step_r <= 1'b1;
                            wrap_r      <= (prev == '0);
                            prev        <= bus.count;
                        end else begin
                            state       <= FAULT;
                            err_r       <= 1'b1;
                            dir_valid_r <= 1'b0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.dir       = dir_r;
    assign bus.dir_valid = dir_valid_r;
    assign bus.up_step   = up_step_r;
    assign bus.down_step = down_step_r;
    assign bus.hold      = hold_r;
    assign bus.wrap      = wrap_r;
    assign bus.err       = err_r;
    assign bus.rev_count = rev_count_r;
endmodule

// File: tb/tb_count_direction_decoder.sv
// Scoreboard bench for count_direction_decoder: the driver queues the expected
// registered response for each cycle, a negedge monitor pops and compares.
module tb_count_direction_decoder;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    count_direction_decoder_if #(.BITS(4)) bus ();

    count_direction_decoder #(.BITS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        string      nm;
        int         due;
        bit         chk_dir;
        logic [6:0] f;    // {dir_valid, dir, up, down, hold, wrap, err}
        logic [7:0] rev;
    } exp_t;

    exp_t q[$];

    always @(negedge clk) begin
        if (q.size() > 0 && q[0].due <= cyc) begin
            exp_t       e;
            logic [6:0] act;
            logic [6:0] mask;
            e    = q.pop_front();
            act  = {bus.dir_valid, bus.dir, bus.up_step, bus.down_step,
                    bus.hold, bus.wrap, bus.err};
            mask = e.chk_dir ? 7'h7F : 7'h5F;
            n_tests++;
            if (((act & mask) !== (e.f & mask)) || (bus.rev_count !== e.rev)) begin
                n_fail++;
                $display("FAIL %s: got flags(dv,dir,up,dn,hold,wrap,err)=%b rev=%0d, want %b rev=%0d",
                         e.nm, act, bus.rev_count, e.f, e.rev);
            end
        end
    end

    task automatic drv(input string nm, input bit r, input bit c, input bit v,
                       input logic [3:0] cnt, input bit dv, input bit d,
                       input bit u, input bit dn, input bit h, input bit w,
                       input bit e, input int rev);
        exp_t x;
        @(posedge clk);
        #2;
        reset           = r ? 1'b0 : 1'b1;
        bus.clear       = c;
        bus.count_valid = v;
        bus.count       = cnt;
        x.nm      = nm;
        x.due     = cyc + 1;
        x.chk_dir = dv || r;
        x.f       = {dv, d, u, dn, h, w, e};
        x.rev     = 8'(rev);
        q.push_back(x);
    endtask

    initial begin
        bus.count       = '0;
        bus.count_valid = 1'b0;
        bus.clear       = 1'b0;

        //  name           rst clr vld cnt  dv dir up dn hd wr er rev
        drv("reset",        1, 0, 0, 4'd0,  0, 0, 0, 0, 0, 0, 0, 0);
        drv("up0_wrap",     0, 0, 1, 4'd0,  1, 1, 1, 0, 0, 1, 0, 0);
        drv("up1",          0, 0, 1, 4'd1,  1, 1, 1, 0, 0, 0, 0, 0);
        drv("up2",          0, 0, 1, 4'd2,  1, 1, 1, 0, 0, 0, 0, 0);
        drv("idle",         0, 0, 0, 4'd9,  1, 1, 0, 0, 0, 0, 0, 0);

        drv("reset2",       1, 0, 0, 4'd0,  0, 0, 0, 0, 0, 0, 0, 0);
        drv("hold15",       0, 0, 1, 4'd15, 0, 0, 0, 0, 1, 0, 0, 0);
        drv("dn14",         0, 0, 1, 4'd14, 1, 0, 0, 1, 0, 0, 0, 0);
        drv("dn13",         0, 0, 1, 4'd13, 1, 0, 0, 1, 0, 0, 0, 0);

        drv("clr_a",        0, 1, 0, 4'd0,  0, 0, 0, 0, 0, 0, 0, 0);
        drv("prime2",       0, 0, 1, 4'd2,  0, 0, 0, 0, 0, 0, 0, 0);
        drv("rv_up3",       0, 0, 1, 4'd3,  1, 1, 1, 0, 0, 0, 0, 0);
        drv("rv_up4",       0, 0, 1, 4'd4,  1, 1, 1, 0, 0, 0, 0, 0);
        drv("rv_dn3",       0, 0, 1, 4'd3,  1, 0, 0, 1, 0, 0, 0, 1);
        drv("rv_up4b",      0, 0, 1, 4'd4,  1, 1, 1, 0, 0, 0, 0, 2);

        drv("illegal7",     0, 0, 1, 4'd7,  0, 0, 0, 0, 0, 0, 1, 2);
        drv("fault_ign8",   0, 0, 1, 4'd8,  0, 0, 0, 0, 0, 0, 1, 2);
        drv("fault_ign5",   0, 0, 1, 4'd5,  0, 0, 0, 0, 0, 0, 1, 2);
        drv("fault_clr",    0, 1, 0, 4'd0,  0, 0, 0, 0, 0, 0, 0, 2);
        drv("empty_s9",     0, 0, 1, 4'd9,  0, 0, 0, 0, 0, 0, 0, 2);
        drv("primed_up10",  0, 0, 1, 4'd10, 1, 1, 1, 0, 0, 0, 0, 2);

        drv("clr_and_vld",  0, 1, 1, 4'd11, 0, 0, 0, 0, 0, 0, 0, 2);
        drv("empty_s3",     0, 0, 1, 4'd3,  0, 0, 0, 0, 0, 0, 0, 2);
        drv("after_up4",    0, 0, 1, 4'd4,  1, 1, 1, 0, 0, 0, 0, 2);

        drv("clr_b",        0, 1, 0, 4'd0,  0, 0, 0, 0, 0, 0, 0, 2);
        drv("empty_s0",     0, 0, 1, 4'd0,  0, 0, 0, 0, 0, 0, 0, 2);
        drv("dn_wrap15",    0, 0, 1, 4'd15, 1, 0, 0, 1, 0, 1, 0, 2);
        drv("hold_in_down", 0, 0, 1, 4'd15, 1, 0, 0, 0, 1, 0, 0, 2);

        drv("illegal3",     0, 0, 1, 4'd3,  0, 0, 0, 0, 0, 0, 1, 2);
        drv("rst_in_fault", 1, 1, 1, 4'd6,  0, 0, 0, 0, 0, 0, 0, 0);
        drv("prev15_wrap",  0, 0, 1, 4'd0,  1, 1, 1, 0, 0, 1, 0, 0);

        // From UP with prev=0, alternate 15/0: every step wraps and reverses.
        for (int i = 1; i <= 300; i++) begin
            if (i % 2 == 1)
                drv("alt_dn", 0, 0, 1, 4'd15, 1, 0, 0, 1, 0, 1, 0, (i > 255) ? 255 : i);
            else
                drv("alt_up", 0, 0, 1, 4'd0,  1, 1, 1, 0, 0, 1, 0, (i > 255) ? 255 : i);
        end
        drv("sat_idle",     0, 0, 0, 4'd0,  1, 1, 0, 0, 0, 0, 0, 255);
        drv("reset_end",    1, 0, 0, 4'd0,  0, 0, 0, 0, 0, 0, 0, 0);

        @(posedge clk);
        #2;
        reset           = 1'b1;
        bus.count_valid = 1'b0;
        bus.clear       = 1'b0;
        for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
        @(negedge clk);
        #1;
        if (q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
